btb_assoc: RTL
==============

# btb_assoc

Parametrised set-associative branch target buffer for the fetch stage of the pipelined core. It is the next generation of the direct-mapped BTB and adds the following:
- configurable set count and way count;
- a 2-bit saturating direction counter per entry;
- miss-driven allocation with per-set round-robin replacement;
- a multi-cycle flush sweep.

Fetch performs a combinational lookup on the current PC, and the execute stage writes resolved branch outcomes back.

## Interface
- PC_W, default 32: PC and target width.
- SETS, default 256: number of sets. Must be a power of two, ≥2. IDX_W = log2(SETS).
- WAYS, default 2: associativity. Legal values are 1, 2, 4.
- Derived widths:
  - TAG_W = PC_W-2-IDX_W;
  - index = pc[IDX_W+1:2];
  - tag = pc[PC_W-1:IDX_W+2].
- Clock and reset: one clock; reset is synchronous and active-high.
  - clk_i  in  1  clock; all state changes on the rising edge.
  - rst_i  in  1  synchronous active-high reset.
- Lookup (fetch):
  - lookup_pc_i  in  PC_W  fetch PC to look up.
  - hit_o  out  1  a valid entry matches the index and tag.
  - target_o  out  PC_W  stored target on hit, 0 otherwise.
  - taken_o  out  1  MSB of the hit entry's counter, 0 on miss.
- Update (execute):
  - upd_valid_i  in  1  a resolved branch update is presented this cycle.
  - upd_pc_i  in  PC_W  PC of the resolved branch.
  - upd_target_i  in  PC_W  resolved target.
  - upd_taken_i  in  1  resolved direction.
- Flush:
  - flush_i  in  1  one-cycle pulse that starts the invalidate sweep.
  - busy_o  out  1  the flush sweep is in progress.

## Operation
- Storage per set and way: valid, tag, target, ctr[1:0]. Storage per set: rr pointer, log2(WAYS) bits (0 bits when WAYS=1).
- Lookup is combinational.
  - hit_o is the OR over ways of (valid & tag match & !busy_o).
  - The single matching way drives target_o and taken_o.
  - At most one way can match, because allocation happens only on a miss.
- Update hit (upd_valid_i, not busy, the tag matches way w):
  - ctr saturates: +1 if taken (max 2'b11), -1 if not taken (min 2'b00).
  - target is overwritten with upd_target_i only when taken.
  - valid stays 1; the rr pointer is unchanged.
- Update miss, taken: allocate an entry with valid=1, tag, target, ctr=2'b10.
  - Victim choice: the lowest-index invalid way.
  - If every way is valid, the victim is way rr, and rr then advances by 1 modulo WAYS.
  - rr does not advance when an invalid way was filled.
- Update miss, not taken: no state change.
- Flush FSM, states IDLE and SWEEP.
  - IDLE→SWEEP on flush_i. The counter cnt is set to 0.
  - In SWEEP, each cycle clears valid for every way of set cnt, resets rr[cnt] to 0, and increments cnt.
  - SWEEP→IDLE after the cycle that clears set SETS-1.
  - busy_o=1 exactly while in SWEEP.
  - While busy: hit_o is forced to 0 and updates are dropped. flush_i asserted during SWEEP is ignored.
- Reset, synchronous and dominant over everything:
  - all valid bits, ctr, rr and cnt are cleared; tags and targets are cleared to 0;
  - the FSM goes to IDLE.
- Output values after reset: hit_o=0, target_o=0, taken_o=0, busy_o=0.
- Reset asserted mid-sweep aborts the sweep and returns the FSM to IDLE with everything cleared.

## Timing
- Lookup latency is 0 cycles (combinational from lookup_pc_i).
- An update is written on the rising edge and becomes visible to lookups the next cycle.
- Same-cycle lookup and update to the same set: the lookup returns the pre-update contents.
- Back-to-back updates to the same entry in consecutive cycles both take effect, and the counter steps twice.
- The flush sweep takes exactly SETS cycles.
  - busy_o rises the cycle after flush_i is sampled and falls SETS cycles later.
  - An update presented on the same cycle flush_i is sampled is still performed; it is then cleared by the sweep.

## Test plan
All scenarios use PC_W=32, SETS=16, WAYS=2.
- Basic allocation: after reset, lookup 0x100 gives hit_o=0. Apply update 0x100, taken, target 0x200. On the next cycle, lookup 0x100 gives hit_o=1, target_o=0x200, taken_o=1 (ctr=10).
- Counter saturation:
  - from the 0x100 entry (ctr=10), two not-taken updates give ctr=00: hit_o=1, taken_o=0, target still 0x200;
  - then four taken updates saturate at ctr=11 with taken_o=1.
- Replacement, all in set 0: update taken for 0x100 (fills way0), then 0x140 (fills way1), then 0x180.
  - 0x180 evicts way0 and rr becomes 1. Lookups then give 0x100 miss, 0x140 hit, 0x180 hit.
  - A further update for 0x1C0 evicts way1 (0x140).
- No allocate on a not-taken miss: update 0x300, not taken, leaves lookup 0x300 at hit_o=0.
  - Update 0x300 taken with lookup 0x300 driven in the same cycle: the lookup misses that cycle and hits the next cycle.
- Flush:
  - populate 4 entries, pulse flush_i;
  - busy_o is 1 for exactly 16 cycles; hit_o stays 0 and an update issued mid-sweep is dropped;
  - after the sweep, all 4 PCs miss.
- Reset mid-sweep: assert rst_i on cycle 5 of SWEEP. On the next cycle busy_o=0 and all lookups miss; a new flush_i then runs the full 16 cycles.

Source files
------------

// File: rtl/btb_assoc.sv
// Set-associative branch target buffer with 2-bit direction counters,
// miss-driven allocation, per-set round-robin replacement and a
// one-set-per-cycle flush sweep.
module btb_assoc #(
  parameter int PC_W = 32,
  parameter int SETS = 256,
  parameter int WAYS = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [PC_W-1:0] lookup_pc_i,
  output logic            hit_o,
  output logic [PC_W-1:0] target_o,
  output logic            taken_o,
  input  logic            upd_valid_i,
  input  logic [PC_W-1:0] upd_pc_i,
  input  logic [PC_W-1:0] upd_target_i,
  input  logic            upd_taken_i,
  input  logic            flush_i,
  output logic            busy_o
);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = PC_W - 2 - IDX_W;
  // rr storage is kept 1 bit wide for WAYS=1 but never advanced there
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic {IDLE, SWEEP} state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;

  logic [SETS-1:0][WAYS-1:0]            valid_q;
  logic [SETS-1:0][WAYS-1:0][TAG_W-1:0] tag_q;
  logic [SETS-1:0][WAYS-1:0][PC_W-1:0]  tgt_q;
  logic [SETS-1:0][WAYS-1:0][1:0]       ctr_q;
  logic [SETS-1:0][WAY_W-1:0]           rr_q;

  // PC bits [1:0] are always word-aligned zero and carry no information
  logic unused_lsbs;
  assign unused_lsbs = ^{lookup_pc_i[1:0], upd_pc_i[1:0]};

  // ---------------- lookup ----------------
  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic [WAYS-1:0]  lk_match;
  logic [PC_W-1:0]  lk_tgt;
  logic [1:0]       lk_ctr;

  assign lk_idx = lookup_pc_i[IDX_W+1:2];
  assign lk_tag = lookup_pc_i[PC_W-1:IDX_W+2];

  // ---------------- update ----------------
  logic [IDX_W-1:0] u_idx;
  logic [TAG_W-1:0] u_tag;
  logic [WAYS-1:0]  u_match;
  logic             u_hit, upd_en, any_inv;
  logic [WAY_W-1:0] hit_way, vic;
  logic [1:0]       ctr_cur, ctr_nxt;

  assign u_idx = upd_pc_i[IDX_W+1:2];
  assign u_tag = upd_pc_i[PC_W-1:IDX_W+2];

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    assign lk_match[w] = valid_q[lk_idx][w] && (tag_q[lk_idx][w] == lk_tag);
    assign u_match[w]  = valid_q[u_idx][w]  && (tag_q[u_idx][w]  == u_tag);
  end

  // Select the (single) matching way's target and counter for fetch
  always_comb begin
    lk_tgt = '0;
    lk_ctr = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (lk_match[w]) begin
        lk_tgt = tgt_q[lk_idx][w];
        lk_ctr = ctr_q[lk_idx][w];
      end
    end
  end

  assign busy_o   = (state_q == SWEEP);
  assign hit_o    = (|lk_match) && !busy_o;
  assign target_o = hit_o ? lk_tgt : '0;
  assign taken_o  = hit_o && lk_ctr[1];

  assign u_hit  = |u_match;
  assign upd_en = upd_valid_i && !busy_o;

  // Find the hit way, and the victim: lowest invalid way, else the rr way
  always_comb begin
    hit_way = '0;
    vic     = rr_q[u_idx];
    any_inv = 1'b0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (u_match[w]) hit_way = WAY_W'(w);
      if (!valid_q[u_idx][w]) begin
        vic     = WAY_W'(w);
        any_inv = 1'b1;
      end
    end
  end

  // Saturating step of the hit entry's direction counter
  always_comb begin
    ctr_cur = ctr_q[u_idx][hit_way];
    ctr_nxt = ctr_cur;
    if (upd_taken_i) begin
      if (ctr_cur != 2'b11) ctr_nxt = ctr_cur + 2'b01;
    end else begin
      if (ctr_cur != 2'b00) ctr_nxt = ctr_cur - 2'b01;
    end
  end

  // ---------------- flush FSM ----------------
  // Next-state: a flush pulse in IDLE starts a sweep over every set
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (flush_i) begin
          state_d = SWEEP;
          cnt_d   = '0;
        end
      end
      SWEEP: begin
        cnt_d = cnt_q + IDX_W'(1);
        if (cnt_q == IDX_W'(SETS - 1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state and sweep counter registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Entry storage: sweep clears one set per cycle, otherwise apply updates
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
      tag_q   <= '0;
      tgt_q   <= '0;
      ctr_q   <= '0;
      rr_q    <= '0;
    end else if (busy_o) begin
      valid_q[cnt_q] <= '0;
      rr_q[cnt_q]    <= '0;
    end else if (upd_en) begin
      if (u_hit) begin
        ctr_q[u_idx][hit_way] <= ctr_nxt;
        if (upd_taken_i) tgt_q[u_idx][hit_way] <= upd_target_i;
      end else if (upd_taken_i) begin
        valid_q[u_idx][vic] <= 1'b1;
        tag_q[u_idx][vic]   <= u_tag;
        tgt_q[u_idx][vic]   <= upd_target_i;
        ctr_q[u_idx][vic]   <= 2'b10;
        if (!any_inv && (WAYS > 1)) rr_q[u_idx] <= rr_q[u_idx] + WAY_W'(1);
      end
    end
  end
endmodule
